// File: rtl/ll_req_sequencer_pkg.sv
// ============================================================================
// param_types : shared list types plus the sequencer command/state types
// Rev 1.0
// ============================================================================
`default_nettype none

package param_types;

  localparam int PTR_WD     = 4;
  localparam int WR_DATA_WD = 8;

  typedef enum logic [1:0] {
    REQ_PUSH,
    REQ_POP,
    REQ_READ,
    REQ_WRITE
  } t_req_types;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_OK,
    RESP_EMPTY,
    RESP_ERR
  } t_resp_types;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    HOLD
  } t_seq_state;

  typedef struct packed {
    t_req_types              req_type;
    logic [PTR_WD-1:0]       pos;
    logic [WR_DATA_WD-1:0]   data;
  } t_cmd;

endpackage

`default_nettype wire

// File: rtl/ll_req_sequencer_cmd_fifo.sv
// ============================================================================
// ll_cmd_fifo : synchronous command FIFO, power-of-two depth, wrapping pointers
// Rev 1.0
// ============================================================================
`default_nettype none

module ll_cmd_fifo
  import param_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  t_cmd                     push_cmd,
  input  logic                     pop,
  output t_cmd                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  t_cmd             r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the top masks the head whenever no request is shown.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_cmd;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ll_req_sequencer.sv
// ============================================================================
// ll_req_sequencer : buffers host commands and issues them one at a time to
// the linked list, returning each response (or a timeout) to the host.
// Rev 1.0
// ============================================================================
`default_nettype none

module ll_req_sequencer
  import param_types::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_WD  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    host_cmd_vld,
  output logic                    host_cmd_rdy,
  input  t_req_types              host_cmd_type,
  input  logic [PTR_WD-1:0]       host_cmd_pos,
  input  logic [WR_DATA_WD-1:0]   host_cmd_data,
  output logic                    req_vld,
  output t_req_types              req_type,
  output logic [PTR_WD-1:0]       req_pos,
  output logic [WR_DATA_WD-1:0]   req_data,
  input  logic                    intf_ready,
  input  logic                    resp_vld,
  input  t_resp_types             resp_type,
  input  logic [WR_DATA_WD-1:0]   resp_data,
  input  logic                    resp_data_vld,
  output logic                    resp_taken,
  output logic                    host_rsp_vld,
  input  logic                    host_rsp_rdy,
  output t_resp_types             host_rsp_type,
  output logic [WR_DATA_WD-1:0]   host_rsp_data,
  output logic                    host_rsp_data_vld,
  output logic                    host_rsp_timeout,
  output logic [CNT_WD-1:0]       drop_cnt
);

  localparam int              CW           = $clog2(DEPTH) + 1;
  localparam int              TW           = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   C_TIMER_LAST = TW'(TIMEOUT - 1);

  t_seq_state                 r_state;
  t_seq_state                 w_state_nxt;
  t_cmd                       w_push_cmd;
  t_cmd                       w_head;
  logic [CW-1:0]              w_count;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_capture;
  logic                       w_expire;
  logic                       w_clr_timer;
  logic                       w_drop;
  logic [TW-1:0]              r_timer;
  t_resp_types                r_rsp_type;
  logic [WR_DATA_WD-1:0]      r_rsp_data;
  logic                       r_rsp_data_vld;
  logic                       r_rsp_timeout;
  logic [CNT_WD-1:0]          r_drop_cnt;

  always_comb begin
    w_push_cmd          = '0;
    w_push_cmd.req_type = host_cmd_type;
    w_push_cmd.pos      = host_cmd_pos;
    w_push_cmd.data     = host_cmd_data;
  end

  assign host_cmd_rdy = (w_count < CW'(DEPTH));
  assign w_push       = host_cmd_vld & ~w_full;

  ll_cmd_fifo #(
    .DEPTH    (DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (w_push),
    .push_cmd (w_push_cmd),
    .pop      (w_pop),
    .head     (w_head),
    .count    (w_count),
    .full     (w_full),
    .empty    (w_empty)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_clr_timer = 1'b0;
    w_capture   = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        if (intf_ready) begin
          w_pop       = 1'b1;
          w_clr_timer = 1'b1;
          w_state_nxt = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // A real response arriving on the expiry cycle takes priority.
        if (resp_vld) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end else if (r_timer == C_TIMER_LAST) begin
          w_expire    = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (host_rsp_rdy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_timer <= '0;
    end else if (w_clr_timer) begin
      r_timer <= '0;
    end else if (r_state == WAIT_RESP) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_rsp_type     <= RESP_NONE;
      r_rsp_data     <= '0;
      r_rsp_data_vld <= 1'b0;
      r_rsp_timeout  <= 1'b0;
    end else if (w_capture) begin
      r_rsp_type     <= resp_type;
      r_rsp_data     <= resp_data;
      r_rsp_data_vld <= resp_data_vld;
      r_rsp_timeout  <= 1'b0;
    end else if (w_expire) begin
      r_rsp_type     <= RESP_NONE;
      r_rsp_data     <= '0;
      r_rsp_data_vld <= 1'b0;
      r_rsp_timeout  <= 1'b1;
    end
  end

  // Responses outside WAIT_RESP belong to no outstanding request.
  assign w_drop = resp_vld & (r_state != WAIT_RESP);

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {CNT_WD{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_WD'(1);
    end
  end

  assign req_vld           = (r_state == ISSUE);
  assign req_type          = req_vld ? w_head.req_type : REQ_PUSH;
  assign req_pos           = req_vld ? w_head.pos      : '0;
  assign req_data          = req_vld ? w_head.data     : '0;
  assign resp_taken        = resp_vld & ~reset_n;
  assign host_rsp_vld      = (r_state == HOLD);
  assign host_rsp_type     = r_rsp_type;
  assign host_rsp_data     = r_rsp_data;
  assign host_rsp_data_vld = r_rsp_data_vld;
  assign host_rsp_timeout  = r_rsp_timeout;
  assign drop_cnt          = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ll_req_sequencer.sv
// ============================================================================
// tb_ll_req_sequencer : directed self-checking bench for ll_req_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ll_req_sequencer;
  import param_types::*;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   host_cmd_vld;
  logic                   host_cmd_rdy;
  t_req_types             host_cmd_type;
  logic [PTR_WD-1:0]      host_cmd_pos;
  logic [WR_DATA_WD-1:0]  host_cmd_data;
  logic                   req_vld;
  t_req_types             req_type;
  logic [PTR_WD-1:0]      req_pos;
  logic [WR_DATA_WD-1:0]  req_data;
  logic                   intf_ready;
  logic                   resp_vld;
  t_resp_types            resp_type;
  logic [WR_DATA_WD-1:0]  resp_data;
  logic                   resp_data_vld;
  logic                   resp_taken;
  logic                   host_rsp_vld;
  logic                   host_rsp_rdy;
  t_resp_types            host_rsp_type;
  logic [WR_DATA_WD-1:0]  host_rsp_data;
  logic                   host_rsp_data_vld;
  logic                   host_rsp_timeout;
  logic [7:0]             drop_cnt;

  int n_chk   = 0;
  int n_pass  = 0;
  int n_taken = 0;

  always #5 clk = ~clk;

  ll_req_sequencer #(
    .DEPTH             (4),
    .TIMEOUT           (64),
    .CNT_WD            (8)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .host_cmd_vld      (host_cmd_vld),
    .host_cmd_rdy      (host_cmd_rdy),
    .host_cmd_type     (host_cmd_type),
    .host_cmd_pos      (host_cmd_pos),
    .host_cmd_data     (host_cmd_data),
    .req_vld           (req_vld),
    .req_type          (req_type),
    .req_pos           (req_pos),
    .req_data          (req_data),
    .intf_ready        (intf_ready),
    .resp_vld          (resp_vld),
    .resp_type         (resp_type),
    .resp_data         (resp_data),
    .resp_data_vld     (resp_data_vld),
    .resp_taken        (resp_taken),
    .host_rsp_vld      (host_rsp_vld),
    .host_rsp_rdy      (host_rsp_rdy),
    .host_rsp_type     (host_rsp_type),
    .host_rsp_data     (host_rsp_data),
    .host_rsp_data_vld (host_rsp_data_vld),
    .host_rsp_timeout  (host_rsp_timeout),
    .drop_cnt          (drop_cnt)
  );

  always @(posedge clk) if (resp_taken) n_taken++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one cycle; a command offered while ready is withdrawn once taken.
  task automatic cyc();
    logic acc;
    acc = host_cmd_vld && host_cmd_rdy;
    @(posedge clk);
    #1;
    if (acc) host_cmd_vld = 1'b0;
  endtask

  task automatic push_cmd(input t_req_types t, input logic [3:0] p, input logic [7:0] d);
    host_cmd_vld  = 1'b1;
    host_cmd_type = t;
    host_cmd_pos  = p;
    host_cmd_data = d;
  endtask

  task automatic wait_req(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (req_vld) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic serve(input logic [7:0] d, input logic [3:0] p, input t_req_types t);
    logic [7:0] nd;
    nd = ~d;
    wait_req("srv_req_seen");
    chk("srv_data", req_data, d);
    chk("srv_pos", req_pos, p);
    chk("srv_type", req_type, t);
    cyc();
    chk("srv_one_outstanding", req_vld, 0);
    resp_vld = 1'b1; resp_type = RESP_OK; resp_data = nd; resp_data_vld = 1'b1;
    #1;
    chk("srv_taken", resp_taken, 1);
    cyc();
    resp_vld = 1'b0; resp_data_vld = 1'b0;
    chk("srv_rsp_vld", host_rsp_vld, 1);
    chk("srv_rsp_data", host_rsp_data, nd);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    t_req_types tlist [4];
    int base;
    tlist = '{REQ_PUSH, REQ_POP, REQ_READ, REQ_WRITE};
    reset_n = 1'b0; host_cmd_vld = 1'b0; host_cmd_type = REQ_PUSH; host_cmd_pos = '0;
    host_cmd_data = '0; intf_ready = 1'b0; resp_vld = 1'b0; resp_type = RESP_NONE;
    resp_data = '0; resp_data_vld = 1'b0; host_rsp_rdy = 1'b0;
    #1 reset_n = 1'b1;
    #1;
    chk("rst_cmd_rdy", host_cmd_rdy, 1);
    chk("rst_req_vld", req_vld, 0);
    chk("rst_req_type", req_type, REQ_PUSH);
    chk("rst_req_pos", req_pos, 0);
    chk("rst_req_data", req_data, 0);
    chk("rst_resp_taken", resp_taken, 0);
    chk("rst_rsp_vld", host_rsp_vld, 0);
    chk("rst_rsp_type", host_rsp_type, RESP_NONE);
    chk("rst_rsp_data", host_rsp_data, 0);
    chk("rst_rsp_dvld", host_rsp_data_vld, 0);
    chk("rst_rsp_to", host_rsp_timeout, 0);
    chk("rst_drop", drop_cnt, 0);
    cyc(); cyc();
    #2 reset_n = 1'b0;
    cyc();

    // Single command, response three cycles after acceptance.
    intf_ready = 1'b1; host_rsp_rdy = 1'b0; base = n_taken;
    push_cmd(REQ_PUSH, 4'd0, 8'hA5);
    cyc();
    chk("t1_req_n1", req_vld, 0);
    cyc();
    chk("t1_req_n2", req_vld, 1);
    chk("t1_req_data", req_data, 8'hA5);
    chk("t1_req_type", req_type, REQ_PUSH);
    cyc();
    chk("t1_req_pulse", req_vld, 0);
    cyc(); cyc();
    resp_vld = 1'b1; resp_type = RESP_OK; resp_data = 8'h5A; resp_data_vld = 1'b1;
    #1;
    chk("t1_taken", resp_taken, 1);
    cyc();
    resp_vld = 1'b0; resp_data_vld = 1'b0;
    #1;
    chk("t1_taken_end", resp_taken, 0);
    chk("t1_rsp_vld", host_rsp_vld, 1);
    chk("t1_rsp_data", host_rsp_data, 8'h5A);
    chk("t1_rsp_type", host_rsp_type, RESP_OK);
    chk("t1_rsp_dvld", host_rsp_data_vld, 1);
    chk("t1_rsp_to", host_rsp_timeout, 0);
    host_rsp_rdy = 1'b1;
    cyc();
    host_rsp_rdy = 1'b0;
    chk("t1_rsp_done", host_rsp_vld, 0);
    chk("t1_taken_once", n_taken - base, 1);

    // Fill the FIFO with the list stalled, then drain in order.
    intf_ready = 1'b0; host_rsp_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_cmd(tlist[i % 4], 4'(i + 1), 8'(8'h10 + i));
      chk("fill_rdy", host_cmd_rdy, (i < 4) ? 1 : 0);
      cyc();
    end
    for (int k = 0; k < 10; k++) begin
      chk("stall_vld", req_vld, 1);
      chk("stall_data", req_data, 8'h10);
      chk("stall_pos", req_pos, 1);
      chk("stall_type", req_type, REQ_PUSH);
      cyc();
    end
    intf_ready = 1'b1;
    for (int i = 0; i < 5; i++) serve(8'(8'h10 + i), 4'(i + 1), tlist[i % 4]);
    chk("drain_empty_rdy", host_cmd_rdy, 1);

    // Timeout, then a late response that must be drained.
    host_rsp_rdy = 1'b0;
    push_cmd(REQ_READ, 4'd3, 8'h77);
    wait_req("to_req_seen");
    for (int k = 1; k <= 64; k++) cyc();
    chk("to_pre", host_rsp_vld, 0);
    cyc();
    chk("to_rsp_vld", host_rsp_vld, 1);
    chk("to_flag", host_rsp_timeout, 1);
    chk("to_data", host_rsp_data, 0);
    chk("to_type", host_rsp_type, RESP_NONE);
    chk("to_dvld", host_rsp_data_vld, 0);
    host_rsp_rdy = 1'b1;
    cyc();
    host_rsp_rdy = 1'b0;
    chk("to_rsp_done", host_rsp_vld, 0);
    for (int k = 0; k < 14; k++) cyc();
    resp_vld = 1'b1; resp_type = RESP_OK; resp_data = 8'h99; resp_data_vld = 1'b1;
    #1;
    chk("late_taken", resp_taken, 1);
    cyc();
    resp_vld = 1'b0; resp_data_vld = 1'b0;
    chk("late_drop", drop_cnt, 1);
    chk("late_no_rsp", host_rsp_vld, 0);

    // Host slow to take a response with a second command queued.
    push_cmd(REQ_PUSH, 4'd1, 8'h21);
    cyc();
    push_cmd(REQ_WRITE, 4'd2, 8'h22);
    cyc();
    wait_req("bp_req_seen");
    chk("bp_first_data", req_data, 8'h21);
    cyc();
    resp_vld = 1'b1; resp_type = RESP_OK; resp_data = 8'h5C; resp_data_vld = 1'b1;
    cyc();
    resp_vld = 1'b0; resp_data_vld = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("bp_one_out", req_vld, 0);
      cyc();
    end
    chk("bp_rsp_vld", host_rsp_vld, 1);
    chk("bp_rsp_data", host_rsp_data, 8'h5C);
    host_rsp_rdy = 1'b1;
    cyc();
    host_rsp_rdy = 1'b0;
    chk("bp_h1", req_vld, 0);
    cyc();
    chk("bp_h2", req_vld, 1);
    chk("bp_h2_data", req_data, 8'h22);
    cyc();

    // Reset in WAIT_RESP with three commands queued.
    for (int i = 0; i < 3; i++) begin
      push_cmd(REQ_READ, 4'(i + 5), 8'(8'h31 + i));
      cyc();
    end
    chk("mid_rsp_none", host_rsp_vld, 0);
    chk("mid_no_req", req_vld, 0);
    #2;
    reset_n = 1'b1; resp_vld = 1'b1;
    #1;
    chk("arst_req_vld", req_vld, 0);
    chk("arst_req_data", req_data, 0);
    chk("arst_cmd_rdy", host_cmd_rdy, 1);
    chk("arst_rsp_vld", host_rsp_vld, 0);
    chk("arst_rsp_data", host_rsp_data, 0);
    chk("arst_taken", resp_taken, 0);
    chk("arst_drop", drop_cnt, 0);
    resp_vld = 1'b0;
    cyc(); cyc();
    #2 reset_n = 1'b0;
    cyc();
    chk("post_cmd_rdy", host_cmd_rdy, 1);
    chk("post_req_vld", req_vld, 0);
    cyc(); cyc();
    chk("post_req_idle", req_vld, 0);
    chk("post_rsp_vld", host_rsp_vld, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ll_req_sequencer.md
# ll_req_sequencer

Host-side command sequencer that sits directly upstream of the linked-list top level. It buffers host commands in a small FIFO and issues them one at a time on the list's req/intf_ready handshake. It captures each response with resp_taken and returns it to the host on a valid/ready port. A response timeout and a stale-response drain keep the host path live if the list stalls.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries (power of 2, ≥2)
- TIMEOUT, 64: cycles waited for resp_vld before a timeout response is synthesised
- CNT_WD, 8: width of drop counter (saturating)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-high reset; the codebase name is kept, asserted = 1
- host_cmd_vld  in  1  host command valid
- host_cmd_rdy  out  1  FIFO can accept
- host_cmd_type  in  t_req_types  request type
- host_cmd_pos  in  PTR_WD  node position
- host_cmd_data  in  WR_DATA_WD  write data
- req_vld  out  1  request to list
- req_type / req_pos / req_data  out  t_req_types / PTR_WD / WR_DATA_WD  FIFO head fields
- intf_ready  in  1  list accepts request
- resp_vld  in  1  list response valid
- resp_type  in  t_resp_types  list response type
- resp_data  in  WR_DATA_WD  list response data
- resp_data_vld  in  1  resp_data meaningful
- resp_taken  out  1  response consumed (combinational)
- host_rsp_vld  out  1  response to host valid
- host_rsp_rdy  in  1  host takes response
- host_rsp_type / host_rsp_data / host_rsp_data_vld  out  t_resp_types / WR_DATA_WD / 1  held response
- host_rsp_timeout  out  1  response was synthesised by timeout
- drop_cnt  out  CNT_WD  stale responses drained

## Operation
- The FIFO pushes when host_cmd_vld && host_cmd_rdy. host_cmd_rdy = (count < DEPTH), computed from the registered count. There is no same-cycle bypass when full.
- FSM states:
  - IDLE: FIFO non-empty → ISSUE.
  - ISSUE: req_vld=1 with FIFO head. On intf_ready: pop FIFO, clear timer, → WAIT_RESP.
  - WAIT_RESP: timer increments each cycle.
    - resp_vld: resp_taken=1 the same cycle; capture type/data/data_vld; timeout=0; → HOLD.
    - Else, when timer==TIMEOUT-1: capture resp_type=default (first enum value), data=0, data_vld=0, timeout=1; → HOLD.
  - HOLD: host_rsp_vld=1. On host_rsp_rdy → IDLE.
- Stale drain: resp_vld in any state other than WAIT_RESP → resp_taken=1 and the response is discarded. drop_cnt increments and saturates at all-ones.
- At most one request is outstanding. req_* is stable while req_vld && !intf_ready.
- Host response fields are registered and stable throughout HOLD.

## Timing
- Reset values:
  - state=IDLE, FIFO empty, host_cmd_rdy=1
  - req_vld=0, req_type=first enum value, req_pos=0, req_data=0
  - resp_taken=0
  - host_rsp_vld=0, host_rsp_type=first enum value, host_rsp_data=0, host_rsp_data_vld=0, host_rsp_timeout=0
  - drop_cnt=0
- Reset is asynchronous and may hit mid-operation. All in-flight commands and held responses are lost, and state returns to IDLE next edge-free.
- Latency, host push in cycle N into an empty FIFO with FSM in IDLE: req_vld first high in N+2.
- Response accepted in cycle M (resp_vld in WAIT_RESP): host_rsp_vld high in M+1.
- After host_rsp_rdy in cycle H: FSM is IDLE in H+1. If the FIFO is non-empty, req_vld is high in H+2.
- Timeout: request accepted in cycle A with no response → host_rsp_vld high in A+TIMEOUT+1.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH, and count is $clog2(DEPTH)+1 bits wide.
- resp_vld in the same cycle as the timeout match: the real response wins, with timeout=0.

## Structure
- t_req_types, t_resp_types, PTR_WD and WR_DATA_WD come from the shared package param_types. Add a new FSM enum t_seq_state {IDLE, ISSUE, WAIT_RESP, HOLD} there.
- One sub-module, ll_cmd_fifo: a parameterised synchronous FIFO holding {type,pos,data}. It exposes push, pop, head, count, full and empty.
- Timer is $clog2(TIMEOUT) bits wide and lives in the top FSM.

## Test plan
- Single push (type=push, data=0xA5, pos=0), intf_ready held 1, resp_vld 3 cycles after acceptance → req_vld at N+2 for 1 cycle; resp_taken pulses once; host_rsp_vld next cycle with data matching the list.
- Push 5 commands with DEPTH=4 and intf_ready=0 → host_cmd_rdy low after the 4th push. Then release intf_ready → 4 requests issued in order; the 5th is accepted once space frees.
- intf_ready low for 10 cycles during ISSUE → req_type/pos/data constant every cycle; single pop.
- No response with TIMEOUT=64 → host_rsp_vld at A+65 with host_rsp_timeout=1. A late resp_vld at A+80 → resp_taken=1, drop_cnt=1, no host response.
- host_rsp_rdy held low 20 cycles with 2 queued commands → only one request outstanding. The second req_vld appears 2 cycles after host_rsp_rdy.
- Assert reset_n mid WAIT_RESP with FIFO count 3 → all outputs at reset values asynchronously; host_cmd_rdy=1 after release.
